// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS storage/decode slice: ALU operation selects,
// main-control ALU classes and R-type funct codes.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_INV = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUC_MEM   = 2'b00,
    ALUC_BEQ   = 2'b01,
    ALUC_RTYPE = 2'b10,
    ALUC_ADDI  = 2'b11
  } alu_class_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  function automatic alu_op_e decode_funct(input logic [5:0] funct);
    unique case (funct)
      FUNCT_ADD: return ALU_ADD;
      FUNCT_SUB: return ALU_SUB;
      FUNCT_AND: return ALU_AND;
      FUNCT_OR:  return ALU_OR;
      FUNCT_NOR: return ALU_NOR;
      FUNCT_SLT: return ALU_SLT;
      default:   return ALU_INV;
    endcase
  endfunction

endpackage

// File: rtl/mips_rf_mem_aluctl_word_mem.sv
// Word-addressed memory: enable-gated combinational read, synchronous write.
// Reset never clears the array; it only suppresses writes.
module word_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned WORDS  = 256,
  localparam int unsigned AW    = $clog2(WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];

  // Reset is in the sensitivity list only so a write can never race its
  // assertion; the contents are deliberately left untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (!rst_i && wen_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (ren_i) begin
      rdata_o = mem_q[addr_i];
    end
  end

endmodule

// File: rtl/mips_rf_mem_aluctl.sv
// Register file (2R/1W), word memory and ALU-control decoder for the 5-stage MIPS.
// Optional RF_WRITE_BYPASS_EN: same-cycle write-to-read forwarding in the register file.
module mips_rf_mem_aluctl
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [4:0]        rf_raA,
  input  logic [4:0]        rf_raB,
  input  logic [4:0]        rf_wa,
  input  logic              rf_wen,
  input  logic [DATA_W-1:0] rf_wd,
  output logic [DATA_W-1:0] rf_rdA,
  output logic [DATA_W-1:0] rf_rdB,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        alu_cntrl,
  input  logic [5:0]        func,
  output logic [3:0]        alu_op
);

  localparam int unsigned MEM_AW = $clog2(MEM_WORDS);

  // Register file
  logic [DATA_W-1:0] rf_q [32];
  logic              rf_we_d;

  assign rf_we_d = rf_wen && (rf_wa != 5'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we_d) begin
      rf_q[rf_wa] <= rf_wd;
    end
  end

  always_comb begin
    rf_rdA = (rf_raA == 5'd0) ? '0 : rf_q[rf_raA];
    rf_rdB = (rf_raB == 5'd0) ? '0 : rf_q[rf_raB];
`ifdef RF_WRITE_BYPASS_EN
    // rf_we_d already excludes r0, so forwarding cannot leak into r0 reads
    if (rf_we_d && (rf_wa == rf_raA)) rf_rdA = rf_wd;
    if (rf_we_d && (rf_wa == rf_raB)) rf_rdB = rf_wd;
`endif
  end

  // Memory: upper address bits are ignored, giving modulo-depth wrap
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:MEM_AW];

  word_mem #(
    .DATA_W (DATA_W),
    .WORDS  (MEM_WORDS)
  ) u_mem (
    .clk_i   (clock),
    .rst_i   (reset),
    .ren_i   (mem_ren),
    .wen_i   (mem_wen),
    .addr_i  (mem_addr[MEM_AW-1:0]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // ALU control
  alu_op_e alu_op_d;

  always_comb begin
    alu_op_d = ALU_ADD;
    unique case (alu_class_e'(alu_cntrl))
      ALUC_MEM:   alu_op_d = ALU_ADD;
      ALUC_BEQ:   alu_op_d = ALU_SUB;
      ALUC_ADDI:  alu_op_d = ALU_ADD;
      ALUC_RTYPE: alu_op_d = decode_funct(func);
      default:    alu_op_d = ALU_INV;
    endcase
  end

  assign alu_op = alu_op_d;

endmodule

// File: tb/tb_mips_rf_mem_aluctl.sv
// Self-checking bench for mips_rf_mem_aluctl: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_mips_rf_mem_aluctl;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [4:0]  rf_raA, rf_raB, rf_wa;
  logic        rf_wen;
  logic [31:0] rf_wd, rf_rdA, rf_rdB;
  logic        mem_ren, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  alu_cntrl;
  logic [5:0]  func;
  logic [3:0]  alu_op;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf_m  [32];
  logic [31:0] mem_m [256];
  logic [3:0]  rtype_tbl [logic [5:0]];

  mips_rf_mem_aluctl #(
    .DATA_W    (32),
    .MEM_WORDS (256)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rf_raA    (rf_raA),
    .rf_raB    (rf_raB),
    .rf_wa     (rf_wa),
    .rf_wen    (rf_wen),
    .rf_wd     (rf_wd),
    .rf_rdA    (rf_rdA),
    .rf_rdB    (rf_rdB),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .alu_cntrl (alu_cntrl),
    .func      (func),
    .alu_op    (alu_op)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_exp(input logic [4:0] a);
    if (a == 5'd0 || reset) return 32'h0;
    if (BYPASS && rf_wen && rf_wa == a) return rf_wd;
    return rf_m[a];
  endfunction

  function automatic logic [3:0] alu_exp(input logic [1:0] c, input logic [5:0] f);
    if (c == 2'b01) return 4'b0110;
    if (c != 2'b10) return 4'b0010;
    if (rtype_tbl.exists(f)) return rtype_tbl[f];
    return 4'b1111;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_rdA"}, rf_rdA, rf_exp(rf_raA));
    check({tag, "_rdB"}, rf_rdB, rf_exp(rf_raB));
    check({tag, "_mem"}, mem_rdata, mem_ren ? mem_m[mem_addr % 256] : 32'h0);
    check({tag, "_alu"}, {28'h0, alu_op}, {28'h0, alu_exp(alu_cntrl, func)});
  endtask

  // Advance one clock edge, apply the architectural effect of the current inputs, settle.
  task automatic step();
    @(posedge clock);
    if (reset) begin
      foreach (rf_m[i]) rf_m[i] = 32'h0;
    end else begin
      if (rf_wen && rf_wa != 5'd0) rf_m[rf_wa] = rf_wd;
      if (mem_wen) mem_m[mem_addr % 256] = mem_wdata;
    end
    #1;
  endtask

  task automatic idle();
    rf_wen = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0;
  endtask

  initial begin
    rtype_tbl[6'h20] = 4'b0010; rtype_tbl[6'h22] = 4'b0110; rtype_tbl[6'h24] = 4'b0000;
    rtype_tbl[6'h25] = 4'b0001; rtype_tbl[6'h27] = 4'b1100; rtype_tbl[6'h2A] = 4'b0111;
    foreach (rf_m[i]) rf_m[i] = 32'h0;

    reset = 1'b1;
    rf_raA = 5'd3; rf_raB = 5'd17; rf_wa = 5'd0; rf_wd = '0;
    mem_addr = '0; mem_wdata = '0; alu_cntrl = 2'b00; func = 6'h00;
    idle();
    #1;
    check("rst_rdA", rf_rdA, 32'h0);
    check("rst_rdB", rf_rdB, 32'h0);
    check("rst_mem_noren", mem_rdata, 32'h0);
    step(); step();
    #3 reset = 1'b0;
    step();

    // Preload every memory word so all later reads are defined
    for (int i = 0; i < 256; i++) begin
      mem_wen = 1'b1; mem_addr = i; mem_wdata = $urandom;
      step();
    end
    idle();

    // Scenario 1: async reset mid-cycle clears r5
    rf_wen = 1'b1; rf_wa = 5'd5; rf_wd = 32'h1234;
    step();
    idle(); rf_raA = 5'd5;
    #1 check("t1_r5_written", rf_rdA, 32'h1234);
    #1 reset = 1'b1;
    foreach (rf_m[i]) rf_m[i] = 32'h0;
    #1 check("t1_async_clear", rf_rdA, 32'h0);

    // Scenario 6: memory write while in reset is blocked
    mem_wen = 1'b1; mem_addr = 32'd10; mem_wdata = ~mem_m[10];
    rf_wen = 1'b1; rf_wa = 5'd9; rf_wd = 32'hCAFE0009;
    step();
    idle();
    #2 reset = 1'b0;
    mem_ren = 1'b1; rf_raB = 5'd9;
    #1 check_model("t6");

    // Scenario 2: r0 writes discarded, r31 write
    rf_wen = 1'b1; rf_wa = 5'd0; rf_wd = 32'hFFFFFFFF;
    step();
    rf_wa = 5'd31; rf_wd = 32'hDEADBEEF; rf_raA = 5'd0; rf_raB = 5'd31;
    #1 check("t2_r0", rf_rdA, 32'h0);
    check("t2_r31_wcycle", rf_rdB, BYPASS ? 32'hDEADBEEF : 32'h0);
    step();
    idle();
    #1 check("t2_r31_next", rf_rdB, 32'hDEADBEEF);

    // Scenario 3: write/read addr 3, ren gating, aliasing of 259
    mem_wen = 1'b1; mem_addr = 32'd3; mem_wdata = 32'hA5A5A5A5;
    step();
    idle(); mem_ren = 1'b1;
    #1 check("t3_read", mem_rdata, 32'hA5A5A5A5);
    mem_ren = 1'b0;
    #1 check("t3_noren", mem_rdata, 32'h0);
    mem_ren = 1'b1; mem_addr = 32'd259;
    #1 check("t3_alias", mem_rdata, 32'hA5A5A5A5);

    // Scenario 4: simultaneous read and write
    mem_wen = 1'b1; mem_addr = 32'd7; mem_wdata = 32'h11;
    step();
    mem_wdata = 32'h22;
    #1 check("t4_old", mem_rdata, 32'h11);
    step();
    mem_wen = 1'b0;
    #1 check("t4_new", mem_rdata, 32'h22);

    // Scenario 5: ALU control sweep
    alu_cntrl = 2'b00; #1 check("t5_lwsw", {28'h0, alu_op}, 32'h2);
    alu_cntrl = 2'b01; #1 check("t5_beq",  {28'h0, alu_op}, 32'h6);
    alu_cntrl = 2'b11; #1 check("t5_addi", {28'h0, alu_op}, 32'h2);
    alu_cntrl = 2'b10;
    func = 6'h20; #1 check("t5_add", {28'h0, alu_op}, 32'h2);
    func = 6'h22; #1 check("t5_sub", {28'h0, alu_op}, 32'h6);
    func = 6'h24; #1 check("t5_and", {28'h0, alu_op}, 32'h0);
    func = 6'h25; #1 check("t5_or",  {28'h0, alu_op}, 32'h1);
    func = 6'h27; #1 check("t5_nor", {28'h0, alu_op}, 32'hC);
    func = 6'h2A; #1 check("t5_slt", {28'h0, alu_op}, 32'h7);
    func = 6'h00; #1 check("t5_inv", {28'h0, alu_op}, 32'hF);
    for (int f = 0; f < 64; f++) begin
      func = f[5:0];
      #1 check("t5_funct_sweep", {28'h0, alu_op}, {28'h0, alu_exp(2'b10, func)});
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rf_wen    = $urandom_range(0, 1);
      rf_wa     = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rf_wd     = $urandom;
      rf_raA    = ($urandom_range(0, 3) == 0) ? rf_wa : 5'($urandom_range(0, 7));
      rf_raB    = 5'($urandom);
      mem_ren   = $urandom_range(0, 1);
      mem_wen   = $urandom_range(0, 1);
      mem_addr  = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
      mem_wdata = $urandom;
      alu_cntrl = 2'($urandom);
      func      = ($urandom_range(0, 1) == 0) ? 6'($urandom) : (6'h20 | 6'($urandom_range(0, 10)));
      #1 check_model("rand");
      step();
    end

    idle();
    #1 check_model("final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
